spi_chip_responder: RTL and testbench

- Chip-side SPI responder: the target end of the link driven by our SPI master (spiClk, CS_B, SPI_SEL, MOSI in; MISO, SPI_CLK_OUT back).
- Receives 64-bit config frames (spi_sel=1) and 32-bit DAC waveform words (spi_sel=0), and returns the previous config frame on MISO.
- Serves as the behavioural and synthesizable chip model on the FPGA test rig and in closed-loop benches against SPI_control.
- Single fast clock domain; all SPI pins are oversampled.

---
 rtl/spi_chip_responder.sv | 195 +++++++++++++++++++
 tb/tb_spi_chip_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spi_chip_responder.sv
// spi_chip_responder: chip-side SPI target (mode 0, MSB first).
// Captures 64-bit config frames (spi_sel=1) and 32-bit waveform words
// (spi_sel=0). All SPI pins are oversampled by clk via SYNC_STAGES flops.
// Optional feature macro: SPI_READBACK_EN -- when defined, miso returns the
// previously committed config frame; when undefined miso is tied low and the
// readback/transmit registers do not exist.
// Debug: dbg_state exposes the FSM state (IDLE=0, SHIFT=1, CHECK=2, COMMIT=3, ERROR=4).
module spi_chip_responder #(
  parameter int CFG_BITS    = 64,
  parameter int WAV_BITS    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spi_clk_in,
  input  logic                cs_b,
  input  logic                spi_sel,
  input  logic                mosi,
  output logic                miso,
  output logic                spi_clk_out,
  output logic [CFG_BITS-1:0] cfg_word,
  output logic                cfg_valid,
  output logic [WAV_BITS-1:0] wav_word,
  output logic                wav_valid,
  output logic                frame_err,
  output logic                busy,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    CHECK  = 3'd2,
    COMMIT = 3'd3,
    ERROR  = 3'd4
  } state_t;

  localparam logic [6:0] CNT_MAX = 7'd127;
  localparam logic [6:0] CFG_CNT = 7'(CFG_BITS);
  localparam logic [6:0] WAV_CNT = 7'(WAV_BITS);

  // Synchronizer chains; index SYNC_STAGES-1 is the settled sample.
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, sel_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;

  state_t               state_q, state_d;
  logic                 sel_q, sel_d;
  logic [6:0]           bit_cnt_q, bit_cnt_d;
  logic [CFG_BITS-1:0]  rx_sh_q, rx_sh_d;
  logic [CFG_BITS-1:0]  cfg_word_q, cfg_word_d;
  logic [WAV_BITS-1:0]  wav_word_q, wav_word_d;
`ifdef SPI_READBACK_EN
  logic [CFG_BITS-1:0]  tx_sh_q, tx_sh_d;
  logic [CFG_BITS-1:0]  readback_q, readback_d;
  logic                 sclk_fall;
`endif

  logic sclk_s, cs_s, sel_s, mosi_s;
  logic sclk_rise, cs_fall, cs_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sel_s     = sel_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
`ifdef SPI_READBACK_EN
  assign sclk_fall = ~sclk_s & sclk_prev_q;
`endif

  // Synchronize the SPI pins and keep one extra stage for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      sel_sync_q  <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_in};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_b};
      sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0], spi_sel};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  // FSM and datapath state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      bit_cnt_q  <= '0;
      rx_sh_q    <= '0;
      cfg_word_q <= '0;
      wav_word_q <= '0;
`ifdef SPI_READBACK_EN
      tx_sh_q    <= '0;
      readback_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sh_q    <= rx_sh_d;
      cfg_word_q <= cfg_word_d;
      wav_word_q <= wav_word_d;
`ifdef SPI_READBACK_EN
      tx_sh_q    <= tx_sh_d;
      readback_q <= readback_d;
`endif
    end
  end

  // Next-state logic. Committed words are loaded on the CHECK->COMMIT edge so
  // they are already visible while the valid pulse is high.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sh_d    = rx_sh_q;
    cfg_word_d = cfg_word_q;
    wav_word_d = wav_word_q;
`ifdef SPI_READBACK_EN
    tx_sh_d    = tx_sh_q;
    readback_d = readback_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = SHIFT;
          sel_d     = sel_s;
          bit_cnt_d = '0;
`ifdef SPI_READBACK_EN
          tx_sh_d   = readback_q;
`endif
        end
      end
      SHIFT: begin
        // A cs_b rise takes priority over any coincident spi_clk edge.
        if (cs_rise) begin
          state_d = CHECK;
        end else begin
          if (sclk_rise) begin
            rx_sh_d = {rx_sh_q[CFG_BITS-2:0], mosi_s};
            if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 7'd1;
          end
`ifdef SPI_READBACK_EN
          if (sclk_fall) begin
            // A waveform frame only carries WAV_BITS of readback.
            if (!sel_q && (bit_cnt_q >= WAV_CNT)) tx_sh_d = '0;
            else tx_sh_d = {tx_sh_q[CFG_BITS-2:0], 1'b0};
          end
`endif
        end
      end
      CHECK: begin
        if (bit_cnt_q == (sel_q ? CFG_CNT : WAV_CNT)) begin
          state_d = COMMIT;
          if (sel_q) begin
            cfg_word_d = rx_sh_q;
`ifdef SPI_READBACK_EN
            readback_d = rx_sh_q;
`endif
          end else begin
            wav_word_d = rx_sh_q[WAV_BITS-1:0];
          end
        end else begin
          state_d = ERROR;
        end
      end
      COMMIT:  state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cfg_valid   = (state_q == COMMIT) & sel_q;
  assign wav_valid   = (state_q == COMMIT) & ~sel_q;
  assign frame_err   = (state_q == ERROR);
  assign busy        = (state_q != IDLE);
  assign cfg_word    = cfg_word_q;
  assign wav_word    = wav_word_q;
  assign spi_clk_out = sclk_prev_q;
  assign dbg_state   = state_q;
`ifdef SPI_READBACK_EN
  assign miso = (state_q == SHIFT) & tx_sh_q[CFG_BITS-1];
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_chip_responder.sv
// Bench for spi_chip_responder: table of directed frames, hand-written reset
// abort sequence, then randomized frames against a frame-level model.
module tb_spi_chip_responder;

  localparam int HALF = 6;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_clk_in, cs_b, spi_sel, mosi;
  logic        miso, spi_clk_out, cfg_valid, wav_valid, frame_err, busy;
  logic [63:0] cfg_word;
  logic [31:0] wav_word;
  logic [2:0]  dbg_state;

  spi_chip_responder #(.CFG_BITS(64), .WAV_BITS(32), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .spi_clk_in(spi_clk_in), .cs_b(cs_b),
    .spi_sel(spi_sel), .mosi(mosi), .miso(miso), .spi_clk_out(spi_clk_out),
    .cfg_word(cfg_word), .cfg_valid(cfg_valid), .wav_word(wav_word),
    .wav_valid(wav_valid), .frame_err(frame_err), .busy(busy),
    .dbg_state(dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Pulse monitor, sampled on the falling edge
  int n_cfgv, n_wavv, n_errv, lat, cs_rise_cyc;
  always @(negedge clk) begin
    if (cfg_valid) begin
      n_cfgv++;
      if (lat < 0) lat = cyc - cs_rise_cyc;
    end
    if (wav_valid) begin
      n_wavv++;
      if (lat < 0) lat = cyc - cs_rise_cyc;
    end
    if (frame_err) n_errv++;
  end

  // Frame-level reference model
  logic [63:0] m_cfg, m_rb;
  logic [31:0] m_wav;

  function automatic logic exp_miso(input logic sel, input int i);
`ifdef SPI_READBACK_EN
    if (i < 64 && (sel || i < 32)) return m_rb[63-i];
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic sel, input logic [63:0] data, input int nbits,
                            input int toggle_at, input int rst_at,
                            output logic aborted, output int miso_bad, output int clk_bad);
    int len;
    len = sel ? 64 : 32;
    miso_bad = 0; clk_bad = 0; aborted = 1'b0;
    n_cfgv = 0; n_wavv = 0; n_errv = 0; lat = -1;
    spi_sel = sel; mosi = 1'b0; cs_b = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b0; wait_clks(3); rst = 1'b1; wait_clks(2);
        aborted = 1'b1;
        break;
      end
      if (i == toggle_at) spi_sel = ~sel;
      mosi = (i < len) ? data[len-1-i] : 1'b0;
      wait_clks(HALF);
      if (miso !== exp_miso(sel, i)) miso_bad++;
      if (spi_clk_out !== 1'b0) clk_bad++;
      spi_clk_in = 1'b1;
      wait_clks(HALF);
      if (spi_clk_out !== 1'b1) clk_bad++;
      spi_clk_in = 1'b0;
    end
    wait_clks(HALF);
    cs_b = 1'b1;
    cs_rise_cyc = cyc;
    wait_clks(12);
  endtask

  // kind: 1 = config commit, 2 = waveform commit, 3 = frame error, 0 = aborted
  task automatic run_frame(input logic sel, input logic [63:0] data, input int nbits,
                           input int toggle_at, input int rst_at, input int kind);
    logic aborted;
    int   miso_bad, clk_bad;
    send_frame(sel, data, nbits, toggle_at, rst_at, aborted, miso_bad, clk_bad);
    if (aborted) begin
      m_cfg = '0; m_rb = '0; m_wav = '0;
    end else if (kind == 1) begin
      m_cfg = data; m_rb = data;
    end else if (kind == 2) begin
      m_wav = data[31:0];
    end
    check("cfg_valid_pulses", 64'(n_cfgv), 64'(kind == 1));
    check("wav_valid_pulses", 64'(n_wavv), 64'(kind == 2));
    check("frame_err_pulses", 64'(n_errv), 64'(kind == 3));
    check("cfg_word", cfg_word, m_cfg);
    check("wav_word", 64'(wav_word), 64'(m_wav));
    check("miso_bits_wrong", 64'(miso_bad), 64'd0);
    check("spi_clk_out_wrong", 64'(clk_bad), 64'd0);
    check("busy_after_frame", 64'(busy), 64'd0);
    if (kind == 1 || kind == 2) check("commit_latency", 64'(lat), 64'(SYNC + 2));
  endtask

  typedef struct {
    logic        sel;
    logic [63:0] data;
    int          nbits;
    int          toggle_at;
    int          kind;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 64'hDEADBEEF_01234567, 64, -1, 1};
    vecs[1] = '{1'b1, 64'h0,                 64, -1, 1};
    vecs[2] = '{1'b0, 64'h0000_8000,         32, -1, 2};
    vecs[3] = '{1'b1, 64'h1111_2222_3333_4444, 63, -1, 3};
    vecs[4] = '{1'b1, 64'h5555_6666_7777_8888, 65, -1, 3};
    vecs[5] = '{1'b1, 64'h0F1E_2D3C_4B5A_6978, 64, 10, 1};
    vecs[6] = '{1'b0, 64'h0000_0000_CAFE_F00D, 0,  -1, 3};
    vecs[7] = '{1'b0, 64'h0000_0000_1234_5678, 33, -1, 3};

    m_cfg = '0; m_rb = '0; m_wav = '0;
    cs_rise_cyc = 0; lat = -1; n_cfgv = 0; n_wavv = 0; n_errv = 0;

    // Reset state, with spi_clk_in high to show spi_clk_out is held
    rst = 1'b0; cs_b = 1'b1; spi_clk_in = 1'b1; spi_sel = 1'b0; mosi = 1'b0;
    wait_clks(5);
    check("rst_cfg_word", cfg_word, 64'd0);
    check("rst_wav_word", 64'(wav_word), 64'd0);
    check("rst_cfg_valid", 64'(cfg_valid), 64'd0);
    check("rst_wav_valid", 64'(wav_valid), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_miso", 64'(miso), 64'd0);
    check("rst_spi_clk_out", 64'(spi_clk_out), 64'd0);
    check("rst_state_idle", 64'(dbg_state), 64'd0);
    spi_clk_in = 1'b0;
    wait_clks(2);
    rst = 1'b1;
    wait_clks(6);

    // Directed table
    for (int v = 0; v < 8; v++)
      run_frame(vecs[v].sel, vecs[v].data, vecs[v].nbits, vecs[v].toggle_at, -1, vecs[v].kind);

    // Reset at bit 40 of a config frame, then a full frame
    run_frame(1'b1, 64'hFFFF_0000_FFFF_0000, 64, -1, 40, 0);
    run_frame(1'b1, 64'hA5A5A5A5_5A5A5A5A, 64, -1, -1, 1);

    // Randomized frames
    for (int r = 0; r < 20; r++) begin
      logic        sel;
      logic [63:0] data;
      int          len, nbits, pick;
      sel  = 1'($urandom_range(0, 1));
      len  = sel ? 64 : 32;
      data = {$urandom, $urandom};
      pick = $urandom_range(0, 3);
      if (pick <= 1)      nbits = len;
      else if (pick == 2) nbits = $urandom_range(0, 1) ? len + 1 : len - 1;
      else                nbits = $urandom_range(0, 70);
      run_frame(sel, data, nbits, -1, -1, (nbits == len) ? (sel ? 1 : 2) : 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
